// File: rtl/serial_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : serial_reg_slave
// Description : 3-wire serial register slave. It receives frames on an
//               asynchronous sclk/sen/sdi interface and runs entirely in the
//               master_clk domain.
//               Frame layout, MSB first: bit 39 = R/W (1 = read),
//               bits 38:32 = address, bits 31:0 = data.
//               An accepted write produces a one-cycle serial_strobe, together
//               with serial_addr and serial_data. A malformed frame produces a
//               one-cycle frame_error and increments a saturating counter.
// Option      : define SERIAL_READBACK_EN to enable read frames. A read frame
//               fetches readback_data and shifts it out on sdo. When the macro
//               is undefined, sdo, sdo_oe and readback_addr are tied to 0.
// Ports       : master_clk, reset_n (async, active low)
//               sen, sclk, sdi       - serial pins (asynchronous)
//               sdo, sdo_oe          - readback pin and its output enable
//               serial_addr/_data    - last accepted write
//               serial_strobe        - one-cycle write pulse
//               readback_addr/_data  - readback word select and value
//               frame_error          - one-cycle discard pulse
//               err_count            - saturating discarded-frame count
// Revision    : 1.0 - initial release
// ============================================================================
module serial_reg_slave #(
  parameter int FRAME_BITS = 40,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 master_clk,
  input  logic                 reset_n,
  input  logic                 sen,
  input  logic                 sclk,
  input  logic                 sdi,
  output logic                 sdo,
  output logic                 sdo_oe,
  output logic [6:0]           serial_addr,
  output logic [31:0]          serial_data,
  output logic                 serial_strobe,
  output logic [6:0]           readback_addr,
  input  logic [31:0]          readback_data,
  output logic                 frame_error,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);
  localparam logic [5:0] CNT_SAT  = 6'(FRAME_BITS + 1);
  localparam logic [5:0] CNT_HDR  = 6'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Synchronisers. Index 0 and 1 are the two sync flops. Index 2 is the
  // delay flop that is used for edge detection.
  logic [2:0] sen_pipe;
  logic [2:0] sclk_pipe;
  logic [1:0] sdi_pipe;

  logic       sen_rise;
  logic       sen_fall;
  logic       sclk_rise;
  logic       sdi_s;

  state_t                  state;
  logic [FRAME_BITS-1:0]   shreg;
  logic [5:0]              bit_cnt;
  logic                    sen_pending;

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      sen_pipe  <= '0;
      sclk_pipe <= '0;
      sdi_pipe  <= '0;
    end else begin
      sen_pipe  <= {sen_pipe[1:0], sen};
      sclk_pipe <= {sclk_pipe[1:0], sclk};
      sdi_pipe  <= {sdi_pipe[0], sdi};
    end
  end

  assign sen_rise  = sen_pipe[1]  & ~sen_pipe[2];
  assign sen_fall  = ~sen_pipe[1] &  sen_pipe[2];
  assign sclk_rise = sclk_pipe[1] & ~sclk_pipe[2];
  assign sdi_s     = sdi_pipe[1];

  // Frame FSM. Write and error outputs are registered on the SHIFT->DONE
  // transition, so they are valid during the single DONE cycle. That edge is
  // the third master_clk edge after the sen pin falls.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      sen_pending   <= 1'b0;
      serial_addr   <= '0;
      serial_data   <= '0;
      serial_strobe <= 1'b0;
      frame_error   <= 1'b0;
      err_count     <= '0;
    end else begin
      serial_strobe <= 1'b0;
      frame_error   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sen_rise || sen_pending) begin
            state       <= ST_SHIFT;
            shreg       <= '0;
            bit_cnt     <= '0;
            sen_pending <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], sdi_s};
            // Stop one count past a full frame so that overlong frames
            // stay distinguishable from full frames.
            if (bit_cnt != CNT_SAT) begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          if (sen_fall) begin
            state <= ST_DONE;
            if (bit_cnt != CNT_FULL) begin
              frame_error <= 1'b1;
              if (err_count != {ERR_CNT_W{1'b1}}) begin
                err_count <= err_count + ERR_CNT_W'(1);
              end
            end else if (!shreg[FRAME_BITS-1]) begin
              serial_strobe <= 1'b1;
              serial_addr   <= shreg[FRAME_BITS-2 -: 7];
              serial_data   <= shreg[31:0];
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          // A sen rise that lands here would otherwise be lost, because
          // the edge pulse lasts only one cycle.
          if (sen_rise) begin
            sen_pending <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_READBACK_EN
  logic        sclk_fall;
  logic        rd_armed;
  logic        rd_load;
  logic [31:0] rd_shift;

  assign sclk_fall = ~sclk_pipe[1] & sclk_pipe[2];

  // After the header is complete, a read frame captures its address. The
  // selected word is loaded on the next cycle. The sclk fall that directly
  // follows header bit 8 is not used for shifting: the master samples bit 31
  // on rise 9.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_armed      <= 1'b0;
      rd_load       <= 1'b0;
      rd_shift      <= '0;
      sdo_oe        <= 1'b0;
      readback_addr <= '0;
    end else begin
      rd_load <= 1'b0;
      if (state == ST_SHIFT && !sen_fall) begin
        if (!rd_armed && bit_cnt == CNT_HDR && shreg[7]) begin
          readback_addr <= shreg[6:0];
          rd_armed      <= 1'b1;
          rd_load       <= 1'b1;
          sdo_oe        <= 1'b1;
        end
        if (rd_load) begin
          rd_shift <= readback_data;
        end else if (rd_armed && sclk_fall && bit_cnt > CNT_HDR) begin
          rd_shift <= {rd_shift[30:0], 1'b0};
        end
      end else begin
        rd_armed <= 1'b0;
        rd_shift <= '0;
        sdo_oe   <= 1'b0;
      end
    end
  end

  assign sdo = rd_shift[31];
`else
  logic unused_readback;

  assign unused_readback = ^readback_data;
  assign sdo             = 1'b0;
  assign sdo_oe          = 1'b0;
  assign readback_addr   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_reg_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_reg_slave
// Description : Directed and randomized frames for serial_reg_slave. The
//               expected results come from a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_reg_slave;

`ifdef SERIAL_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic        master_clk = 1'b0;
  logic        reset_n    = 1'b0;
  logic        sen        = 1'b0;
  logic        sclk       = 1'b0;
  logic        sdi        = 1'b0;
  logic        sdo;
  logic        sdo_oe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic [6:0]  readback_addr;
  logic [31:0] readback_data;
  logic        frame_error;
  logic [7:0]  err_count;

  logic [31:0] rb_mem [128];

  int total = 0;
  int bad   = 0;
  int strobe_seen = 0;
  int err_seen    = 0;
  int exp_strobes = 0;
  int exp_errs    = 0;

  // Reference model state
  logic [6:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_err  = 0;
  logic [6:0]  m_rba  = '0;

  serial_reg_slave dut (
    .master_clk    (master_clk),
    .reset_n       (reset_n),
    .sen           (sen),
    .sclk          (sclk),
    .sdi           (sdi),
    .sdo           (sdo),
    .sdo_oe        (sdo_oe),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .readback_addr (readback_addr),
    .readback_data (readback_data),
    .frame_error   (frame_error),
    .err_count     (err_count)
  );

  assign readback_data = rb_mem[readback_addr];

  always #5 master_clk = ~master_clk;

  always @(negedge master_clk) begin
    if (serial_strobe === 1'b1) strobe_seen++;
    if (frame_error === 1'b1) err_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {sdo, sdo_oe, serial_strobe, frame_error, serial_addr,
              serial_data, readback_addr, err_count}, 64'd0);
  endtask

  // Sends the low nbits of bits, MSB first, with sclk = master_clk/8.
  // When abort_at >= 0, reset is pulsed instead of sending that bit.
  task automatic send_frame(input logic [63:0] bits, input int nbits, input int abort_at);
    logic [31:0] rd_word;
    logic        hdr_rd;
    logic        exp_stb;
    logic        exp_e;
    int          oe_bad;
    rd_word = '0;
    oe_bad  = 0;
    hdr_rd  = (nbits >= 8) ? bits[nbits-1] : 1'b0;
    @(negedge master_clk);
    sen = 1'b1;
    repeat (4) @(negedge master_clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        reset_n = 1'b0;
        sen     = 1'b0;
        sclk    = 1'b0;
        sdi     = 1'b0;
        #1;
        chk_all_zero("reset_async_outputs");
        repeat (3) @(negedge master_clk);
        chk_all_zero("reset_held_outputs");
        reset_n = 1'b1;
        m_addr = '0; m_data = '0; m_err = 0; m_rba = '0;
        repeat (4) @(negedge master_clk);
        chk("err_after_reset", err_count, 64'd0);
        return;
      end
      sdi = bits[nbits-1-i];
      repeat (4) @(negedge master_clk);
      if (i >= 8) begin
        rd_word = {rd_word[30:0], sdo};
        if (sdo_oe !== (RB_EN & hdr_rd)) oe_bad++;
      end
      sclk = 1'b1;
      repeat (4) @(negedge master_clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge master_clk);
    sen = 1'b0;

    exp_stb = 1'b0;
    exp_e   = 1'b0;
    if (nbits != 40) begin
      exp_e = 1'b1;
      exp_errs++;
      if (m_err < 255) m_err++;
    end else if (bits[39] == 1'b0) begin
      exp_stb = 1'b1;
      exp_strobes++;
      m_addr = bits[38:32];
      m_data = bits[31:0];
    end
    if (hdr_rd) m_rba = RB_EN ? bits[nbits-2 -: 7] : 7'd0;

    repeat (2) @(posedge master_clk);
    #1;
    chk("strobe_early", serial_strobe, 64'd0);
    @(posedge master_clk);
    #1;
    chk("strobe_3rd_edge", serial_strobe, exp_stb);
    chk("frame_error", frame_error, exp_e);
    chk("serial_addr", serial_addr, m_addr);
    chk("serial_data", serial_data, m_data);
    @(posedge master_clk);
    #1;
    chk("strobe_one_cycle", serial_strobe, 64'd0);
    chk("error_one_cycle", frame_error, 64'd0);
    chk("err_count", err_count, m_err);
    chk("oe_window", oe_bad, 64'd0);
    chk("oe_after_frame", sdo_oe, 64'd0);
    chk("readback_addr", readback_addr, m_rba);
    if (nbits == 40 && bits[39] == 1'b1) begin
      chk("readback_word", rd_word, RB_EN ? rb_mem[bits[38:32]] : 32'd0);
    end
    @(negedge master_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lens [9] = '{40, 40, 40, 40, 39, 41, 8, 12, 0};
    logic [63:0] f;
    int n;

    for (int i = 0; i < 128; i++) rb_mem[i] = $urandom;
    rb_mem[7'h20] = 32'h12345678;

    repeat (3) @(negedge master_clk);
    chk_all_zero("reset_state");
    reset_n = 1'b1;
    repeat (2) @(negedge master_clk);

    // Basic write
    send_frame({24'd0, 1'b0, 7'h05, 32'hDEADBEEF}, 40, -1);
    // Short frame and long frame
    send_frame({25'd0, 39'h02_CAFE_F00D}, 39, -1);
    send_frame({23'd0, 1'b0, 7'h33, 32'h11112222, 1'b1}, 41, -1);
    chk("err_after_short_long", err_count, 64'd2);
    // Read frame
    send_frame({24'd0, 1'b1, 7'h20, 32'h0}, 40, -1);
    // Reset mid-frame, then a full write
    send_frame({24'd0, 1'b0, 7'h11, 32'h55AA55AA}, 40, 20);
    send_frame({24'd0, 1'b0, 7'h7F, 32'h00000001}, 40, -1);
    // Back-to-back writes with the minimum sen gap
    send_frame({24'd0, 1'b0, 7'h01, 32'h0000000A}, 40, -1);
    send_frame({24'd0, 1'b0, 7'h02, 32'h0000000B}, 40, -1);
    // Randomized frames
    for (int k = 0; k < 16; k++) begin
      n = lens[$urandom_range(0, 8)];
      f = {$urandom, $urandom};
      f = (n == 0) ? 64'd0 : (f & ((64'd1 << n) - 64'd1));
      send_frame(f, n, -1);
    end
    // Error counter saturation
    for (int k = 0; k < 256; k++) send_frame(64'd0, 0, -1);
    chk("err_saturated", err_count, 64'hFF);

    repeat (4) @(negedge master_clk);
    chk("strobe_pulse_total", strobe_seen, exp_strobes);
    chk("error_pulse_total", err_seen, exp_errs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
